// File: rtl/read_burst_scheduler.sv
// read_burst_scheduler
//   Arbitrates between cluster units for a read of the shared element memory.
//   For each burst it issues 2*BURST_WORDS contiguous half-word reads and the
//   delayed decoder_read_now capture strobes. It counts the double words
//   reported by the packer, forwards them to the winner, and pulses done.
//
// Ports
//   clk, rst_n          : clock (rising edge) and synchronous active-low reset
//   req, req_base       : per-requester level request and start address
//   mem_addr, mem_rd    : memory read address / enable (1-cycle read latency)
//   decoder_read_now    : packer capture strobe, mem_rd delayed by one cycle
//   outsider_read_now   : packer pulse, one per assembled double word
//   grant               : one-hot winner, held for the whole burst
//   rd_valid            : grant qualified by outsider_read_now while busy
//   done                : one-cycle pulse to the winner after its last word
//   busy                : high whenever the scheduler is not idle
//
// Build option
//   RR_ARB_EN : round-robin arbitration. The search starts after the last
//               winner. When undefined, arbitration is fixed priority and
//               the lowest index wins.
module read_burst_scheduler #(
  parameter int NO_OF_REQ   = 4,
  parameter int ADDR_WIDTH  = 10,
  parameter int BURST_WORDS = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NO_OF_REQ-1:0]            req,
  input  logic [NO_OF_REQ*ADDR_WIDTH-1:0] req_base,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_rd,
  output logic                            decoder_read_now,
  input  logic                            outsider_read_now,
  output logic [NO_OF_REQ-1:0]            grant,
  output logic [NO_OF_REQ-1:0]            rd_valid,
  output logic [NO_OF_REQ-1:0]            done,
  output logic                            busy
);

  localparam int BEATS  = 2 * BURST_WORDS;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int WORD_W = $clog2(BURST_WORDS + 1);
  localparam int IDX_W  = (NO_OF_REQ > 1) ? $clog2(NO_OF_REQ) : 1;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [WORD_W-1:0] WORD_ALL  = WORD_W'(BURST_WORDS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]            state_r;
  logic [BEAT_W-1:0]     beat_cnt_r;
  logic [WORD_W-1:0]     word_cnt_r;
  logic [WORD_W-1:0]     word_cnt_s;
  logic                  word_inc_s;
  logic [IDX_W-1:0]      start_idx_s;
  logic [IDX_W-1:0]      cand_idx_s;
  logic [IDX_W-1:0]      win_idx_s;
  logic                  win_found_s;
  logic [NO_OF_REQ-1:0]  grant_s;
  logic [ADDR_WIDTH-1:0] base_s;

`ifdef RR_ARB_EN
  logic [IDX_W-1:0] rr_ptr_r;
  assign start_idx_s = rr_ptr_r;
`else
  assign start_idx_s = {IDX_W{1'b0}};
`endif

  // Arbiter: first requester found when scanning upward from start_idx_s
  always_comb begin
    win_idx_s   = {IDX_W{1'b0}};
    win_found_s = 1'b0;
    cand_idx_s  = {IDX_W{1'b0}};
    for (int k = 0; k < NO_OF_REQ; k++) begin
      cand_idx_s = IDX_W'((int'(start_idx_s) + k) % NO_OF_REQ);
      if (!win_found_s && req[cand_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Winner's one-hot grant and its start address
  always_comb begin
    grant_s = NO_OF_REQ'(1'b1) << win_idx_s;
    base_s  = {ADDR_WIDTH{1'b0}};
    for (int i = 0; i < NO_OF_REQ; i++) begin
      if (win_idx_s == IDX_W'(i)) begin
        base_s = req_base[i*ADDR_WIDTH +: ADDR_WIDTH];
      end else begin
        base_s = base_s;
      end
    end
  end

  // Packer pulses count only while reads are in flight. The counter
  // saturates at a full burst.
  always_comb begin
    word_inc_s = outsider_read_now &&
                 ((state_r == ST_ISSUE) || (state_r == ST_DRAIN)) &&
                 (word_cnt_r != WORD_ALL);
    if (word_inc_s) begin
      word_cnt_s = word_cnt_r + WORD_W'(1);
    end else begin
      word_cnt_s = word_cnt_r;
    end
  end

  assign busy     = (state_r != ST_IDLE);
  assign rd_valid = grant & {NO_OF_REQ{outsider_read_now & busy}};

  // Burst sequencer: grant, address/beat generation, word counting, done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grant      <= {NO_OF_REQ{1'b0}};
      done       <= {NO_OF_REQ{1'b0}};
      mem_rd     <= 1'b0;
      mem_addr   <= {ADDR_WIDTH{1'b0}};
      beat_cnt_r <= {BEAT_W{1'b0}};
      word_cnt_r <= {WORD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= {NO_OF_REQ{1'b0}};
          if (win_found_s) begin
            state_r    <= ST_ISSUE;
            grant      <= grant_s;
            mem_addr   <= base_s;
            mem_rd     <= 1'b1;
            beat_cnt_r <= {BEAT_W{1'b0}};
            word_cnt_r <= {WORD_W{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          word_cnt_r <= word_cnt_s;
          beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
          if (beat_cnt_r == BEAT_LAST) begin
            mem_rd   <= 1'b0;
            mem_addr <= {ADDR_WIDTH{1'b0}};
            state_r  <= ST_DRAIN;
          end else begin
            // Address wraps naturally at 2^ADDR_WIDTH
            mem_addr <= mem_addr + ADDR_WIDTH'(1);
          end
        end
        ST_DRAIN: begin
          word_cnt_r <= word_cnt_s;
          if (word_cnt_s == WORD_ALL) begin
            state_r <= ST_DONE;
            done    <= grant;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          done       <= {NO_OF_REQ{1'b0}};
          grant      <= {NO_OF_REQ{1'b0}};
          beat_cnt_r <= {BEAT_W{1'b0}};
          word_cnt_r <= {WORD_W{1'b0}};
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Capture strobe trails the read enable by the memory's one-cycle latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decoder_read_now <= 1'b0;
    end else begin
      decoder_read_now <= mem_rd;
    end
  end

`ifdef RR_ARB_EN
  // Round-robin pointer: search resumes just after the latest winner
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= {IDX_W{1'b0}};
    end else if ((state_r == ST_IDLE) && win_found_s) begin
      if (win_idx_s == IDX_W'(NO_OF_REQ - 1)) begin
        rr_ptr_r <= {IDX_W{1'b0}};
      end else begin
        rr_ptr_r <= win_idx_s + IDX_W'(1);
      end
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`endif

endmodule
